mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Shares one line-wide backing-memory port between the instruction-side cache (I, read-only
//   line fills) and the data-side cache (D, line fills and write-backs).
//   Sits between both caches and main memory. One transaction in flight; requesters that lose
//   arbitration wait on valid/ready. Round-robin grant, registered response routing, watchdog.
// PARAMETERS
//   ADDR_WIDTH  32   request address width (line-aligned; low bits passed through unchanged)
//   LINE_BITS   128  width of one cache line transfer
//   TIMEOUT     255  max cycles in ISSUE+WAIT before watchdog abort (>=2)
// PORTS
//   clk            in   1           clock, all state updates on posedge
//   reset          in   1           synchronous, active-high
//   i_req_valid    in   1           I-side read request
//   i_req_addr     in   ADDR_WIDTH  I-side line address
//   i_req_ready    out  1           I-side request accepted this cycle
//   i_resp_valid   out  1           one-cycle pulse: i_resp_data valid
//   i_resp_data    out  LINE_BITS   returned line for I-side
//   d_req_valid    in   1           D-side request
//   d_req_rw       in   1           1 = write-back, 0 = line fill
//   d_req_addr     in   ADDR_WIDTH  D-side line address
//   d_req_data     in   LINE_BITS   write-back line
//   d_req_ready    out  1           D-side request accepted this cycle
//   d_resp_valid   out  1           one-cycle pulse: fill data / write ack
//   d_resp_data    out  LINE_BITS   returned line (0 for write ack)
//   mem_req_valid  out  1           request to memory, held until mem_req_ready
//   mem_req_rw     out  1           1 = write
//   mem_req_addr   out  ADDR_WIDTH  memory address
//   mem_req_data   out  LINE_BITS   write data
//   mem_req_ready  in   1           memory accepts request
//   mem_resp_valid in   1           memory response (read data or write ack)
//   mem_resp_data  in   LINE_BITS   memory read data
//   busy           out  1           state != IDLE
//   err_timeout    out  1           sticky watchdog flag, cleared only by reset
// BEHAVIOUR
//   Reset: state=IDLE, last_grant=I, all outputs 0, latched request/counter/err cleared.
//   FSM IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE: if exactly one *_req_valid, grant it; if both, grant the side != last_grant
//     (first tie after reset goes to D). Winner's *_req_ready=1 combinationally this cycle
//     only; loser's ready=0. On accept, latch owner/rw/addr/data (I forces rw=0, data=0),
//     update last_grant, go ISSUE. *_req_ready is 0 in every other state.
//   ISSUE: mem_req_valid=1 with latched fields, stable until mem_req_ready=1 -> WAIT.
//   WAIT: on mem_resp_valid, register mem_resp_data (D write: register 0) into owner's
//     resp_data and pulse owner's resp_valid next cycle; go IDLE in that same edge.
//   Latency: accept at cycle T; mem_req_valid from T+1; memory ready at T+1 and response
//     L cycles later -> owner resp_valid at T+L+2. Non-owner resp_valid never asserts.
//   Back-to-back: the cycle resp_valid pulses the FSM is IDLE and may accept a new request.
//   resp_data holds last value until next response; resp_valid is a single-cycle pulse.
//   mem_resp_valid outside WAIT (incl. same cycle as mem_req_ready) is ignored.
//   Watchdog: 8-bit-or-wider counter cleared on accept, +1 each cycle in ISSUE/WAIT; when it
//     reaches TIMEOUT: set err_timeout, pulse owner resp_valid with data 0, go IDLE.
//   Reset mid-transaction: immediate IDLE, no response pulse; a late memory response is ignored.
//   Requester may drop *_req_valid before accept; nothing is latched, no side effects.
// TESTING
//   Reset, then I read 0x100, mem ready at once, resp L=3 -> i_req_ready@T, i_resp_valid@T+5 w/ data.
//   I and D valid same cycle after reset -> D granted first; I granted next IDLE cycle; strict alternation.
//   D write 0x200 data 0xDEAD..., mem_req_ready low 4 cycles -> mem fields stable; d_resp_valid w/ data 0.
//   Memory never responds, TIMEOUT=8 -> err_timeout=1 at 8 cycles, owner resp_valid w/ 0, busy=0; sticky.
//   Reset asserted during WAIT, then stray mem_resp_valid -> no resp_valid, err_timeout=0, last_grant=I.
//   Spurious mem_resp_valid in IDLE -> no resp pulse, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide backing-memory port between the I-cache
// (read-only line fills) and the D-cache (line fills and write-backs).
// One transaction in flight, round-robin grant on ties, registered response
// routing back to the owner, and a watchdog that aborts a stalled transfer.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 128,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ready,
    output logic                  i_resp_valid,
    output logic [LINE_BITS-1:0]  i_resp_data,
    input  logic                  d_req_valid,
    input  logic                  d_req_rw,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [LINE_BITS-1:0]  d_req_data,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,
    output logic [LINE_BITS-1:0]  d_resp_data,
    output logic                  mem_req_valid,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_BITS-1:0]  mem_req_data,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [LINE_BITS-1:0]  mem_resp_data,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // Watchdog counter is at least 8 bits wide, wider if TIMEOUT needs it.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // Abort fires on the cycle the counter would step onto TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]            state_q,   state_d;
    logic                  last_d_q,  last_d_d;   // 1: D side won the last grant
    logic                  owner_d_q, owner_d_d;  // 1: in-flight transfer belongs to D
    logic                  rw_q,      rw_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [LINE_BITS-1:0]  data_q,    data_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  err_q,     err_d;
    logic                  i_rv_q,    i_rv_d;
    logic                  d_rv_q,    d_rv_d;
    logic [LINE_BITS-1:0]  i_rd_q,    i_rd_d;
    logic [LINE_BITS-1:0]  d_rd_q,    d_rd_d;
    logic                  grant_i,   grant_d;

    // Grant decision: only in IDLE; a tie goes to the side that did not win last.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (i_req_valid && d_req_valid) begin
                grant_d = ~last_d_q;
                grant_i = last_d_q;
            end else begin
                grant_i = i_req_valid;
                grant_d = d_req_valid;
            end
        end
    end

    // Next-state logic: accept/latch, issue to memory, wait for response or watchdog.
    always_comb begin
        logic                 finish;
        logic [LINE_BITS-1:0] resp_line;

        state_d   = state_q;
        last_d_d  = last_d_q;
        owner_d_d = owner_d_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        i_rv_d    = 1'b0;
        d_rv_d    = 1'b0;
        i_rd_d    = i_rd_q;
        d_rd_d    = d_rd_q;
        finish    = 1'b0;
        resp_line = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_i || grant_d) begin
                    owner_d_d = grant_d;
                    last_d_d  = grant_d;
                    rw_d      = grant_d & d_req_rw;
                    addr_d    = grant_d ? d_req_addr : i_req_addr;
                    data_d    = grant_d ? d_req_data : '0;
                    cnt_d     = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                // A real response in WAIT takes precedence over a same-cycle watchdog expiry.
                if (state_q == S_WAIT && mem_resp_valid) begin
                    finish    = 1'b1;
                    resp_line = rw_q ? '0 : mem_resp_data;
                end else if (cnt_q == CNT_LAST) begin
                    finish    = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == S_ISSUE && mem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            state_d = S_IDLE;
            if (owner_d_q) begin
                d_rv_d = 1'b1;
                d_rd_d = resp_line;
            end else begin
                i_rv_d = 1'b1;
                i_rd_d = resp_line;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_d_q  <= 1'b0;
            owner_d_q <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            i_rv_q    <= 1'b0;
            d_rv_q    <= 1'b0;
            i_rd_q    <= '0;
            d_rd_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            owner_d_q <= owner_d_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            i_rv_q    <= i_rv_d;
            d_rv_q    <= d_rv_d;
            i_rd_q    <= i_rd_d;
            d_rd_q    <= d_rd_d;
        end
    end

    assign i_req_ready   = grant_i;
    assign d_req_ready   = grant_d;
    assign i_resp_valid  = i_rv_q;
    assign i_resp_data   = i_rd_q;
    assign d_resp_valid  = d_rv_q;
    assign d_resp_data   = d_rd_q;
    assign mem_req_valid = (state_q == S_ISSUE);
    assign mem_req_rw    = rw_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_data  = data_q;
    assign busy          = (state_q != S_IDLE);
    assign err_timeout   = err_q;

endmodule
